// File: rtl/aes_shiftrows_colbuf.sv
// Column-serial ShiftRows buffer: gathers four 32-bit columns, then replays them permuted
// one column per handshake toward MixColumns, carrying a per-block last-round flag.
module aes_shiftrows_colbuf #(
  parameter bit INVERSE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_col,
  output logic        out_last
);

  typedef enum logic [0:0] {StLoad, StDrain} state_e;

  state_e     state_q;
  logic [1:0] cnt_q;
  logic       last_q;
  logic [7:0] s_q [4][4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= 2'd0;
      last_q  <= 1'b0;
      // Zeroed so out_data is X-free straight out of reset.
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          s_q[r][c] <= 8'h00;
        end
      end
    end else if (state_q == StLoad) begin
      if (in_valid) begin
        for (int r = 0; r < 4; r++) begin
          s_q[r][cnt_q] <= in_data[31-8*r -: 8];
        end
        if (cnt_q == 2'd0) begin
          last_q <= in_last;
        end
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_q <= StDrain;
        end
      end
    end else begin
      if (out_ready) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_q <= StLoad;
        end
      end
    end
  end

  logic [1:0] src_col;

  // Row r of output column cnt is read from column cnt+r (forward) or cnt-r (inverse).
  always_comb begin
    out_data = 32'h0;
    src_col  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      src_col = INVERSE ? (cnt_q - 2'(r)) : (cnt_q + 2'(r));
      out_data[31-8*r -: 8] = s_q[r][src_col];
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDrain);
  assign out_col   = cnt_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_aes_shiftrows_colbuf.sv
// Bench for aes_shiftrows_colbuf: forward and inverse instances share stimulus; a monitor
// scores every output column against a queue filled from observed input transfers.
module tb_aes_shiftrows_colbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_last0;
  logic [31:0] out_data0;
  logic [1:0]  out_col0;
  logic        in_ready1, out_valid1, out_last1;
  logic [31:0] out_data1;
  logic [1:0]  out_col1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  col;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  aes_shiftrows_colbuf #(.INVERSE(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_data  (out_data0),
    .out_col   (out_col0),
    .out_last  (out_last0)
  );

  aes_shiftrows_colbuf #(.INVERSE(1'b1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_col   (out_col1),
    .out_last  (out_last1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ShiftRows on a packed block (column k at [127-32k -: 32], row r within a column).
  function automatic logic [31:0] perm(input logic [127:0] blk, input int col, input bit inv);
    logic [31:0] res;
    int          src;
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      src = inv ? ((col - r + 4) % 4) : ((col + r) % 4);
      res[31-8*r -: 8] = blk[127-32*src-8*r -: 8];
    end
    return res;
  endfunction

  logic [127:0] mdl_blk;
  int           mdl_idx = 0;
  logic         mdl_last;
  exp_t         e;
  exp_t         got;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready0) begin
        mdl_blk[127-32*mdl_idx -: 32] = in_data;
        if (mdl_idx == 0) mdl_last = in_last;
        mdl_idx++;
        if (mdl_idx == 4) begin
          mdl_idx = 0;
          for (int c = 0; c < 4; c++) begin
            e.col  = 2'(c);
            e.last = mdl_last;
            e.data = perm(mdl_blk, c, 1'b0);
            q0.push_back(e);
            e.data = perm(mdl_blk, c, 1'b1);
            q1.push_back(e);
          end
        end
      end
      if (out_valid0 && out_ready) begin
        check("sb0_nonempty", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          got = q0.pop_front();
          check("sb0_data", out_data0, got.data);
          check("sb0_col", 32'(out_col0), 32'(got.col));
          check("sb0_last", 32'(out_last0), 32'(got.last));
        end
      end
      if (out_valid1 && out_ready) begin
        check("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          got = q1.pop_front();
          check("sb1_data", out_data1, got.data);
          check("sb1_col", 32'(out_col1), 32'(got.col));
          check("sb1_last", 32'(out_last1), 32'(got.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high after the block so a following call runs back-to-back.
  task automatic send_block(input logic [127:0] blk, input logic last, output int stalls);
    int w;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = blk[127-32*k -: 32];
      in_last  = (k == 0) ? last : 1'(k % 2);
      w = 0;
      while (!in_ready0 && w < 50) begin
        tick();
        stalls++;
        w++;
      end
      check("in_accept", 32'(in_ready0), 32'd1);
      tick();
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (out_valid0 && w < 100) begin
      tick();
      w++;
    end
    check("drain_done", 32'(out_valid0), 32'd0);
  endtask

  localparam logic [127:0] BlkSeq  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BlkFips = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BlkVec  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    int stalls;
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_col", 32'(out_col0), 32'd0);
    check("rst_out_last", 32'(out_last0), 32'd0);
    check("rst_data_known", 32'($isunknown(out_data0)), 32'd0);
    rst = 1'b0;
    tick();

    // Basic block, latency and literal vectors for both directions.
    send_block(BlkSeq, 1'b0, stalls);
    in_valid = 1'b0;
    check("latency_valid", 32'(out_valid0), 32'd1);
    check("latency_ready", 32'(in_ready0), 32'd0);
    check("fwd_col0", out_data0, 32'h00050a0f);
    check("inv_col0", out_data1, 32'h000d0a07);
    wait_idle();
    check("idle_in_ready", 32'(in_ready0), 32'd1);

    // Backpressure at column 1.
    send_block(BlkSeq, 1'b0, stalls);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_data", out_data0, 32'h04090e03);
      check("bp_col", 32'(out_col0), 32'd1);
      check("bp_in_ready", 32'(in_ready0), 32'd0);
      check("bp_valid", 32'(out_valid0), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // Back-to-back blocks with last flags, in_valid held high between them.
    send_block(BlkFips, 1'b1, stalls);
    send_block(BlkVec, 1'b0, stalls);
    in_valid = 1'b0;
    check("b2b_stalls", 32'(stalls), 32'd4);
    wait_idle();

    // Reset while draining column 2.
    send_block(BlkFips, 1'b1, stalls);
    in_valid = 1'b0;
    w = 0;
    while (out_col0 != 2'd2 && w < 10) begin
      tick();
      w++;
    end
    check("mid_col2", 32'(out_col0), 32'd2);
    rst = 1'b1;
    tick();
    check("mrst_out_valid", 32'(out_valid0), 32'd0);
    check("mrst_in_ready", 32'(in_ready0), 32'd1);
    check("mrst_out_last", 32'(out_last0), 32'd0);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    mdl_idx = 0;
    send_block(BlkVec, 1'b0, stalls);
    in_valid = 1'b0;
    check("fresh_col", 32'(out_col0), 32'd0);
    wait_idle();

    tick();
    check("sb0_empty", 32'(q0.size()), 32'd0);
    check("sb1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
